// File: rtl/cpu2_core.sv
// cpu2_core: multi-cycle CPU with fetch handshake, 8-entry register file, ALU, branches and HALT.
// Optional carry flag with ADC/BCS when CPU2_CARRY_EN is defined.
module cpu2_core #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 8
) (
  input  logic              clk,
  input  logic              res,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_data,
  output logic              halted,
  output logic [2:0]        state,
  output logic              wb_en,
  output logic [2:0]        wb_sel,
  output logic [DATA_W-1:0] wb_data
);

  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_ID   = 3'd1;
  localparam logic [2:0] S_REG  = 3'd2;
  localparam logic [2:0] S_EX   = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_HALT = 3'd5;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_SHL  = 4'h7;
  localparam logic [3:0] OP_SHR  = 4'h8;
  localparam logic [3:0] OP_MOV  = 4'h9;
  localparam logic [3:0] OP_LDI  = 4'hA;
  localparam logic [3:0] OP_BEQZ = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_ADC  = 4'hD;
  localparam logic [3:0] OP_BCS  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  logic [2:0]        r_state, w_next;
  logic              r_req, r_halted;
  logic [PC_W-1:0]   r_pc, r_npc, w_npc, w_off;
  logic [15:0]       r_ir;
  logic [DATA_W-1:0] r_rf [8];
  logic [DATA_W-1:0] r_l, r_r, r_res, w_res;
  logic              r_wb_en, w_we;
  logic [2:0]        r_wb_sel;
  logic [3:0]        w_op;

`ifdef CPU2_CARRY_EN
  logic              r_c, r_c_nxt, w_c_nxt;
  logic [DATA_W:0]   w_add, w_sub, w_adc;
  assign w_add = {1'b0, r_l} + {1'b0, r_r};
  assign w_sub = {1'b0, r_l} - {1'b0, r_r};
  assign w_adc = w_add + {{DATA_W{1'b0}}, r_c};
`endif

  assign w_op      = r_ir[15:12];
  assign w_off     = PC_W'($signed(r_ir[5:0]));
  assign imem_req  = r_req;
  assign imem_addr = r_pc;
  assign halted    = r_halted;
  assign state     = r_state;
  assign wb_en     = r_wb_en;
  assign wb_sel    = r_wb_sel;
  assign wb_data   = r_res;

  // Sequencer next-state decision
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IF:   if (imem_ack) w_next = S_ID; else w_next = S_IF;
      S_ID:   w_next = S_REG;
      S_REG:  w_next = S_EX;
      S_EX:   w_next = S_WB;
      S_WB:   if (w_op == OP_HALT) w_next = S_HALT; else w_next = S_IF;
      S_HALT: w_next = S_HALT;
      default: w_next = S_IF;
    endcase
  end

  // State register; request and halt flags are registered from the next state
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state  <= S_IF;
      r_req    <= 1'b1;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_req    <= (w_next == S_IF);
      r_halted <= (w_next == S_HALT);
    end
  end

  // ALU result, write enable and branch target computed in EX
  always_comb begin
    w_res = {DATA_W{1'b0}};
    w_we  = 1'b0;
    w_npc = r_pc + {{(PC_W-1){1'b0}}, 1'b1};
`ifdef CPU2_CARRY_EN
    w_c_nxt = r_c;
`endif
    case (w_op)
`ifdef CPU2_CARRY_EN
      OP_ADD:  begin w_res = w_add[DATA_W-1:0]; w_we = 1'b1; w_c_nxt = w_add[DATA_W]; end
      OP_SUB:  begin w_res = w_sub[DATA_W-1:0]; w_we = 1'b1; w_c_nxt = w_sub[DATA_W]; end
      OP_ADC:  begin w_res = w_adc[DATA_W-1:0]; w_we = 1'b1; w_c_nxt = w_adc[DATA_W]; end
      OP_BCS:  if (r_c) w_npc = r_pc + w_off; else w_npc = r_pc + {{(PC_W-1){1'b0}}, 1'b1};
`else
      OP_ADD:  begin w_res = r_l + r_r; w_we = 1'b1; end
      OP_SUB:  begin w_res = r_l - r_r; w_we = 1'b1; end
`endif
      OP_AND:  begin w_res = r_l & r_r; w_we = 1'b1; end
      OP_OR:   begin w_res = r_l | r_r; w_we = 1'b1; end
      OP_XOR:  begin w_res = r_l ^ r_r; w_we = 1'b1; end
      OP_NOT:  begin w_res = ~r_l; w_we = 1'b1; end
      OP_SHL:  begin w_res = {r_l[DATA_W-2:0], 1'b0}; w_we = 1'b1; end
      OP_SHR:  begin w_res = {1'b0, r_l[DATA_W-1:1]}; w_we = 1'b1; end
      OP_MOV:  begin w_res = r_l; w_we = 1'b1; end
      OP_LDI:  begin w_res = DATA_W'(r_ir[7:0]); w_we = 1'b1; end
      OP_BEQZ: if (r_l == {DATA_W{1'b0}}) w_npc = r_pc + w_off; else w_npc = r_pc + {{(PC_W-1){1'b0}}, 1'b1};
      OP_JMP:  w_npc = PC_W'(r_l);
      OP_HALT: w_npc = r_pc;
      default: begin w_res = {DATA_W{1'b0}}; w_we = 1'b0; end
    endcase
  end

  // Datapath: IR fetch, operand latch, EX results, and the WB commit of register/PC/carry
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_pc     <= {PC_W{1'b0}};
      r_npc    <= {PC_W{1'b0}};
      r_ir     <= 16'h0000;
      r_l      <= {DATA_W{1'b0}};
      r_r      <= {DATA_W{1'b0}};
      r_res    <= {DATA_W{1'b0}};
      r_wb_en  <= 1'b0;
      r_wb_sel <= 3'd0;
      for (int i = 0; i < 8; i++) r_rf[i] <= {DATA_W{1'b0}};
`ifdef CPU2_CARRY_EN
      r_c      <= 1'b0;
      r_c_nxt  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IF:  if (imem_ack) r_ir <= imem_data;
        S_REG: begin
          r_l <= r_rf[r_ir[8:6]];
          r_r <= r_rf[r_ir[5:3]];
        end
        S_EX: begin
          r_res    <= w_res;
          r_wb_en  <= w_we;
          r_wb_sel <= r_ir[11:9];
          r_npc    <= w_npc;
`ifdef CPU2_CARRY_EN
          r_c_nxt  <= w_c_nxt;
`endif
        end
        S_WB: begin
          if (r_wb_en) r_rf[r_wb_sel] <= r_res;
          r_pc    <= r_npc;
          r_wb_en <= 1'b0;
`ifdef CPU2_CARRY_EN
          r_c     <= r_c_nxt;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu2_core.sv
// Self-checking bench for cpu2_core: directed program steps plus random instructions
// compared against an instruction-level reference model.
module tb_cpu2_core;
  localparam int DW = 16;
  localparam int PW = 8;
  localparam longint DM = longint'(1) << DW;
  localparam longint PM = longint'(1) << PW;

  logic          clk = 1'b0;
  logic          res;
  logic          imem_req;
  logic [PW-1:0] imem_addr;
  logic          imem_ack;
  logic [15:0]   imem_data;
  logic          halted;
  logic [2:0]    state;
  logic          wb_en;
  logic [2:0]    wb_sel;
  logic [DW-1:0] wb_data;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] m_r [8];
  logic [PW-1:0] m_pc;
  logic          m_c;
  logic [DW-1:0] last_wb;

  cpu2_core #(.DATA_W(DW), .PC_W(PW)) dut (
    .clk(clk), .res(res), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .halted(halted), .state(state),
    .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] enc(input int op, input int o, input int l, input int r);
    return {4'(op), 3'(o), 3'(l), 3'(r), 3'b000};
  endfunction

  function automatic logic [15:0] enci(input int op, input int o, input int imm);
    return {4'(op), 3'(o), 1'b0, 8'(imm)};
  endfunction

  function automatic logic [15:0] encb(input int op, input int l, input int off6);
    return {4'(op), 3'b000, 3'(l), 6'(off6)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = '0;
    m_pc = '0;
    m_c  = 1'b0;
  endtask

  task automatic do_reset();
    res = 1'b1;
    imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_wb_en", 32'(wb_en), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd1);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    res = 1'b0;
    model_reset();
  endtask

  // Fetch with 'waits' stall cycles, run through WB, compare against the ISA model.
  task automatic exec_one(input logic [15:0] ins, input int waits);
    int op, off;
    longint L, R, t;
    logic [DW-1:0] o;
    logic we;
    logic [PW-1:0] npc;
    for (int i = 0; i < waits; i++) begin
      chk("if_wait_state", 32'(state), 32'd0);
      chk("if_wait_req", 32'(imem_req), 32'd1);
      chk("if_wait_addr", 32'(imem_addr), 32'(m_pc));
      imem_ack = 1'b0;
      imem_data = 16'($urandom);
      @(negedge clk);
    end
    chk("if_state", 32'(state), 32'd0);
    chk("if_req", 32'(imem_req), 32'd1);
    chk("if_addr", 32'(imem_addr), 32'(m_pc));
    chk("if_wb_en", 32'(wb_en), 32'd0);
    imem_ack = 1'b1;
    imem_data = ins;
    @(negedge clk);
    for (int s = 1; s <= 3; s++) begin
      chk("pipe_state", 32'(state), 32'(s));
      chk("pipe_req", 32'(imem_req), 32'd0);
      chk("pipe_wb_en", 32'(wb_en), 32'd0);
      imem_ack = 1'($urandom_range(0, 1));
      imem_data = 16'($urandom);
      @(negedge clk);
    end
    op = int'(ins[15:12]);
    L = longint'(m_r[ins[8:6]]);
    R = longint'(m_r[ins[5:3]]);
    off = int'(ins[5:0]);
    if (ins[5]) off = off - 64;
    o = '0;
    we = 1'b1;
    npc = PW'((longint'(m_pc) + 1) % PM);
    case (op)
      1: begin t = L + R; o = DW'(t % DM); m_c = (t >= DM); end
      2: begin t = L - R + DM; o = DW'(t % DM); m_c = (L < R); end
      3: o = m_r[ins[8:6]] & m_r[ins[5:3]];
      4: o = m_r[ins[8:6]] | m_r[ins[5:3]];
      5: o = m_r[ins[8:6]] ^ m_r[ins[5:3]];
      6: o = DW'(DM - 1 - L);
      7: o = DW'((L * 2) % DM);
      8: o = DW'(L / 2);
      9: o = DW'(L);
      10: o = DW'(ins[7:0]);
      11: begin we = 1'b0; if (L == 0) npc = PW'((longint'(m_pc) + off + PM) % PM); end
      12: begin we = 1'b0; npc = PW'(L % PM); end
`ifdef CPU2_CARRY_EN
      13: begin t = L + R + longint'(m_c); o = DW'(t % DM); m_c = (t >= DM); end
      14: begin we = 1'b0; if (m_c) npc = PW'((longint'(m_pc) + off + PM) % PM); end
`endif
      15: begin we = 1'b0; npc = m_pc; end
      default: we = 1'b0;
    endcase
    chk("wb_state", 32'(state), 32'd4);
    chk("wb_en", 32'(wb_en), 32'(we));
    if (we) begin
      chk("wb_sel", 32'(wb_sel), 32'(ins[11:9]));
      chk("wb_data", 32'(wb_data), 32'(o));
      m_r[ins[11:9]] = o;
    end
    last_wb = wb_data;
    m_pc = npc;
    imem_ack = 1'b0;
    @(negedge clk);
    chk("next_state", 32'(state), (op == 15) ? 32'd5 : 32'd0);
    chk("next_pc", 32'(imem_addr), 32'(m_pc));
  endtask

  initial begin
    logic [15:0] ins;
    imem_ack = 1'b0;
    imem_data = 16'h0000;
    res = 1'b1;
    @(negedge clk);
    do_reset();

    exec_one(16'hA205, 0);
    chk("ldi_val", 32'(last_wb), 32'h0005);
    chk("ldi_pc", 32'(imem_addr), 32'd1);
    exec_one(enci(10, 2, 7), 3);
    exec_one(enc(2, 3, 1, 2), 1);
    chk("sub_val", 32'(last_wb), 32'hFFFE);
    exec_one(encb(11, 0, 6'h3E), 0);
    chk("beqz_taken_pc", 32'(imem_addr), 32'd1);
    exec_one(enc(1, 4, 3, 2), 0);
    chk("add_val", 32'(last_wb), 32'h0005);
    exec_one(encb(11, 1, 6'h3E), 2);
    chk("beqz_not_taken_pc", 32'(imem_addr), 32'd3);
    exec_one(enci(10, 5, 8'hFF), 0);
    exec_one(enc(7, 6, 5, 0), 0);
    exec_one(enci(10, 7, 1), 0);
    exec_one(enc(4, 5, 6, 7), 0);
    chk("or_val", 32'(last_wb), 32'h01FF);
    exec_one(enc(12, 0, 5, 0), 1);
    chk("jmp_pc", 32'(imem_addr), 32'hFF);
    exec_one(16'h0000, 0);
    chk("wrap_pc", 32'(imem_addr), 32'd0);
    exec_one(enc(13, 0, 0, 0), 0);
    chk("opd_pc", 32'(imem_addr), 32'd1);

    for (int n = 0; n < 80; n++) begin
      ins = 16'($urandom);
      if (ins[15:12] == 4'hF) ins[15:12] = 4'h1;
      exec_one(ins, $urandom_range(0, 2));
    end

    for (int i = 0; i < 8; i++) exec_one(enci(10, i, i + 8'h11), 0);
    exec_one(enci(10, 1, 6), 0);
    exec_one(enc(12, 0, 1, 0), 0);
    chk("pre_halt_pc", 32'(imem_addr), 32'd6);
    exec_one(16'hF000, 1);
    for (int i = 0; i < 20; i++) begin
      imem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("halt_state", 32'(state), 32'd5);
      chk("halt_flag", 32'(halted), 32'd1);
      chk("halt_req", 32'(imem_req), 32'd0);
      chk("halt_pc", 32'(imem_addr), 32'd6);
      chk("halt_wb_en", 32'(wb_en), 32'd0);
    end
    do_reset();
    for (int i = 0; i < 8; i++) begin
      exec_one(enc(9, i, i, 0), 0);
      chk("reg_cleared", 32'(last_wb), 32'd0);
    end

    do_reset();
    exec_one(enci(10, 1, 3), 0);
    imem_ack = 1'b1;
    imem_data = enc(1, 2, 1, 1);
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_at_ex", 32'(state), 32'd3);
    res = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_wb_en", 32'(wb_en), 32'd0);
      chk("abort_state", 32'(state), 32'd0);
      chk("abort_pc", 32'(imem_addr), 32'd0);
    end
    res = 1'b0;
    model_reset();
    exec_one(enc(9, 2, 2, 0), 0);
    chk("abort_no_write", 32'(last_wb), 32'd0);
    exec_one(enc(9, 1, 1, 0), 0);
    chk("abort_r1_clear", 32'(last_wb), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cpu2_core.md
Name: cpu2_core

Overview:
- Parametrised successor to the fixed 16-bit, five-state CPU top: one module holding sequencer, PC, instruction register, 8-entry register file and ALU.
- Adds a program counter, an imem request/acknowledge fetch handshake (wait states), conditional and indirect branches, immediate load and a halt state.
- Data width and PC width are parameters; the instruction word stays 16 bits.
- Top of the CPU2 subsystem; instruction memory is external.

Parameters:
- DATA_W, 16, register/ALU width; legal values ≥ 8.
- PC_W, 8, program-counter and imem address width; legal values ≥ 6.

Ports:
- clk  in  1  system clock, rising edge.
- res  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request.
- imem_addr  out  PC_W  fetch address (equals PC).
- imem_ack  in  1  fetch data valid this cycle.
- imem_data  in  16  instruction word.
- halted  out  1  core is in HALT.
- state  out  3  current state: IF=0, ID=1, REG=2, EX=3, WB=4, HALT=5.
- wb_en  out  1  register write this cycle.
- wb_sel  out  3  destination register index.
- wb_data  out  DATA_W  value written.

Behaviour:
- Reset: state=IF, PC=0, IR=0, R0..R7=0, operand latches 0, wb_en=0, halted=0. Assertion of res mid-instruction aborts it, with no write and no PC update.
- imem_addr always equals PC. imem_req=1 only in state IF.
- IF: stays in IF until imem_ack=1 at a rising edge. On that edge, IR<=imem_data and next state is ID. imem_ack outside IF is ignored.
- ID → REG → EX → WB: one cycle each. An instruction whose ack arrives in the first IF cycle takes 5 cycles; each extra wait cycle adds 1.
- REG latches L=R[INST[8:6]] and R=R[INST[5:3]].
- EX computes the result and the branch decision.
- WB performs the register write and PC update, then moves to IF (or HALT for the HALT opcode).
- Instruction fields: OP=[15:12], OSEL=[11:9], LSEL=[8:6], RSEL=[5:3], off6=[5:0] (signed), imm8=[7:0].
- Opcodes:
  - 0 NOP
  - 1 ADD: O=L+R
  - 2 SUB: O=L−R
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 NOT: O=~L
  - 7 SHL: O=L<<1
  - 8 SHR: O=L>>1, logical
  - 9 MOV: O=L
  - A LDI: O=zero-extended imm8
  - B BEQZ: if L==0, PC<=PC+sext(off6); no register write
  - C JMP: PC<=L[PC_W-1:0]; no register write
  - D, E: reserved, treated as NOP (see optional feature)
  - F HALT
- Arithmetic is modulo 2^DATA_W. PC arithmetic is modulo 2^PC_W (wraps 2^PC_W−1 → 0; backward offsets wrap below 0).
- Default PC update in WB is PC+1. The PC update for an instruction happens only in its WB cycle.
- All eight registers are writable, including R0. A source equal to the destination reads the old value, because operands are latched in REG.
- wb_en, wb_sel and wb_data are valid only in a WB cycle with a register write; otherwise wb_en=0.
- HALT: WB moves to HALT, PC is not incremented, halted=1, imem_req=0. The core stays in HALT until res.

Optional Feature:
- Macro: CPU2_CARRY_EN.
- Defined:
  - Adds a carry flag C, reset value 0.
  - ADD sets C to the carry-out. SUB sets C to the borrow (1 when L<R unsigned). ADC sets C to its carry-out.
  - C is updated in WB only; all other opcodes leave C unchanged.
  - Opcode D = ADC: O=L+R+C.
  - Opcode E = BCS: if C==1, PC<=PC+sext(off6).
- Not defined: no C register; opcodes D and E are NOP (PC+1, no write).

Test Plan:
- Reset, then fetch LDI R1,0x05 (0xA205) with imem_ack=1 on the first IF cycle → wb_en=1, wb_sel=1, wb_data=0x0005 in the 5th cycle; PC 0→1.
- Hold imem_ack=0 for 3 cycles → imem_req stays 1 and imem_addr stays constant; the instruction completes 3 cycles later; ack pulses in ID/EX are ignored.
- R1=5, R2=7; SUB R3,R1,R2 → R3=0xFFFE (DATA_W=16). ADD R4,R3,R2 → R4=0x0005; with CPU2_CARRY_EN, C=1 after each of these instructions.
- BEQZ with L=0 and off6=0x3E at PC=3 → PC=1. With L≠0 → PC=4. JMP with L=0x1FF and PC_W=8 → PC=0xFF, then PC+1 wraps to 0.
- HALT at PC=6 → state=5, halted=1, imem_req=0 for 20 cycles, PC=6. Assert res → state=0, PC=0, registers cleared.
- Assert res during EX of an ADD → no wb_en pulse, PC=0. Opcode D without the macro → NOP, PC+1.
